// File: rtl/sqrt_prenorm_pkg.sv
// Shared FPU definitions for the square-root pre-normalisation stage:
// binary32 field layout, special constants, FSM states, and the helpers
// that turn a normalised mantissa/exponent pair into the core's operands.
package sqrt_prenorm_pkg;

  // binary32 layout
  localparam int FP32_W     = 32;
  localparam int EXP_W      = 8;
  localparam int FRAC_W     = 23;
  localparam int MANT_W     = FRAC_W + 1;
  localparam int EXP_BIAS   = 127;

  // Working exponent is a signed value wide enough for -149..+127
  localparam int E_W        = 10;

  // Radicand fed to the 50-in/25-out square-root core (xx.48 fixed point)
  localparam int RADICAND_W = 50;

  // NORM-cycle counter; a nonzero fraction needs at most 23 shifts
  localparam int CNT_W      = 5;
  localparam logic [CNT_W-1:0] NORM_LAST = 5'd22;

  // Special results
  localparam logic [FP32_W-1:0] QNAN = 32'h7FC0_0000;
  localparam logic [FP32_W-1:0] PINF = 32'h7F80_0000;

  // Subnormal operands behave as if their exponent were 1-bias
  localparam logic signed [E_W-1:0] E_SUBNORM = -10'sd126;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ISSUE = 2'd2
  } state_e;

  typedef struct packed {
    logic sign;
    logic is_nan;
    logic is_inf;
    logic is_zero;
    logic is_sub;
  } fp32_class_t;

  // Align the mantissa so the radicand carries an even exponent: an odd
  // exponent moves one extra bit into the integer part.
  function automatic logic [RADICAND_W-1:0] form_radicand(
    input logic [MANT_W-1:0] mant,
    input logic              e_odd
  );
    logic [RADICAND_W-1:0] rad;
    if (e_odd) begin
      rad = {mant, 26'b0};
    end else begin
      rad = {1'b0, mant, 25'b0};
    end
    return rad;
  endfunction

  // Result exponent: floor(e/2) rebiased; e is signed so >>> floors.
  function automatic logic [EXP_W-1:0] form_exp(
    input logic signed [E_W-1:0] e
  );
    return EXP_W'((e >>> 1) + 10'sd127);
  endfunction

endpackage

// File: rtl/sqrt_prenorm_classify.sv
// Combinational binary32 operand classifier, shared by the FPU stages.
// Flags are mutually consistent: exactly one of nan/inf/zero/sub is set
// for non-normal operands, none for normal ones; sign is the raw bit.
module fp32_classify
  import sqrt_prenorm_pkg::*;
(
  input  logic [FP32_W-1:0] operand,
  output fp32_class_t       cls
);

  logic [EXP_W-1:0]  exp_field_s;
  logic [FRAC_W-1:0] frac_field_s;
  logic              exp_ones_s;
  logic              exp_zero_s;
  logic              frac_zero_s;

  assign exp_field_s  = operand[FP32_W-2:FRAC_W];
  assign frac_field_s = operand[FRAC_W-1:0];
  assign exp_ones_s   = (exp_field_s == 8'hFF);
  assign exp_zero_s   = (exp_field_s == 8'h00);
  assign frac_zero_s  = (frac_field_s == 23'd0);

  // Decode the exponent/fraction fields into operand classes
  always_comb begin
    cls.sign    = operand[FP32_W-1];
    cls.is_nan  = exp_ones_s & ~frac_zero_s;
    cls.is_inf  = exp_ones_s &  frac_zero_s;
    cls.is_zero = exp_zero_s &  frac_zero_s;
    cls.is_sub  = exp_zero_s & ~frac_zero_s;
  end

endmodule

// File: rtl/sqrt_prenorm.sv
// Square-root pre-normaliser: accepts a binary32 operand, resolves special
// operands directly, normalises subnormals one bit per cycle, and hands a
// 50-bit radicand plus biased result exponent to the iterative sqrt core.
module sqrt_prenorm
  import sqrt_prenorm_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [FP32_W-1:0]     operand,
  input  logic                  core_busy,
  output logic                  core_start,
  output logic [RADICAND_W-1:0] radicand,
  output logic [EXP_W-1:0]      exp_out,
  output logic                  special_valid,
  output logic [FP32_W-1:0]     special_result,
  output logic                  invalid
);

  // ---------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------
  state_e                  state_q, state_d;
  logic [MANT_W-1:0]       mant_q, mant_d;
  logic signed [E_W-1:0]   e_q, e_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [RADICAND_W-1:0]   radicand_q, radicand_d;
  logic [EXP_W-1:0]        exp_q, exp_d;
  logic                    special_valid_q, special_valid_d;
  logic [FP32_W-1:0]       special_result_q, special_result_d;
  logic                    invalid_q, invalid_d;

  fp32_class_t             cls_s;
  logic                    is_special_s;
  logic                    accept_s;
  logic                    in_ready_s;
  logic                    core_start_s;
  logic [MANT_W-1:0]       mant_shift_s;
  logic signed [E_W-1:0]   e_dec_s;
  logic signed [E_W-1:0]   e_norm_s;
  logic                    norm_done_s;
  logic                    load_issue_s;
  logic [FP32_W-1:0]       spec_res_s;
  logic                    spec_inv_s;

  // ---------------------------------------------------------------------
  // Operand classification
  // ---------------------------------------------------------------------
  fp32_classify u_classify (
    .operand (operand),
    .cls     (cls_s)
  );

  assign is_special_s = cls_s.is_nan | cls_s.is_inf | cls_s.is_zero | cls_s.sign;
  assign accept_s     = in_valid & in_ready_s;

  // Unbiased exponent of a normal operand
  assign e_norm_s     = $signed({2'b00, operand[FP32_W-2:FRAC_W]}) - 10'sd127;

  // One normalisation step; the counter bound only backs up the bit test
  assign mant_shift_s = mant_q << 1'b1;
  assign e_dec_s      = e_q - 10'sd1;
  assign norm_done_s  = mant_shift_s[MANT_W-1] | (count_q == NORM_LAST);

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  // State register; reset abandons any operation in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; specials never leave IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && !is_special_s) begin
          if (cls_s.is_sub) begin
            state_d = ST_NORM;
          end else begin
            state_d = ST_ISSUE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_NORM: begin
        if (norm_done_s) begin
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_NORM;
        end
      end
      ST_ISSUE: begin
        if (!core_busy) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs; the start pulse ends with the ISSUE state so it can
  // never repeat in the following cycle
  always_comb begin
    in_ready_s   = 1'b0;
    core_start_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready_s = 1'b1;
      end
      ST_NORM: begin
        in_ready_s = 1'b0;
      end
      ST_ISSUE: begin
        core_start_s = ~core_busy;
      end
      default: begin
        in_ready_s   = 1'b0;
        core_start_s = 1'b0;
      end
    endcase
  end

  assign in_ready   = in_ready_s;
  assign core_start = core_start_s;

  // ---------------------------------------------------------------------
  // Mantissa / exponent working registers
  // ---------------------------------------------------------------------
  // Load on accept, shift left one bit per NORM cycle
  always_comb begin
    mant_d  = mant_q;
    e_d     = e_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && !is_special_s) begin
          mant_d  = {~cls_s.is_sub, operand[FRAC_W-1:0]};
          count_d = 5'd0;
          if (cls_s.is_sub) begin
            e_d = E_SUBNORM;
          end else begin
            e_d = e_norm_s;
          end
        end else begin
          mant_d = mant_q;
        end
      end
      ST_NORM: begin
        mant_d  = mant_shift_s;
        e_d     = e_dec_s;
        count_d = count_q + 5'd1;
      end
      ST_ISSUE: begin
        mant_d = mant_q;
      end
      default: begin
        mant_d  = mant_q;
        e_d     = e_q;
        count_d = count_q;
      end
    endcase
  end

  // Working register update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mant_q  <= 24'd0;
      e_q     <= 10'sd0;
      count_q <= 5'd0;
    end else begin
      mant_q  <= mant_d;
      e_q     <= e_d;
      count_q <= count_d;
    end
  end

  // ---------------------------------------------------------------------
  // Core operands: captured on entry to ISSUE and then held until the
  // next normalised operand arrives, so the core may sample them late
  // ---------------------------------------------------------------------
  assign load_issue_s = (state_d == ST_ISSUE) && (state_q != ST_ISSUE);

  // Form radicand and result exponent from the next-state mantissa/exponent
  always_comb begin
    if (load_issue_s) begin
      radicand_d = form_radicand(mant_d, e_d[0]);
      exp_d      = form_exp(e_d);
    end else begin
      radicand_d = radicand_q;
      exp_d      = exp_q;
    end
  end

  // Core operand registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      radicand_q <= 50'd0;
      exp_q      <= 8'd0;
    end else begin
      radicand_q <= radicand_d;
      exp_q      <= exp_d;
    end
  end

  assign radicand = radicand_q;
  assign exp_out  = exp_q;

  // ---------------------------------------------------------------------
  // Special-operand bypass
  // ---------------------------------------------------------------------
  // Select the bypass result; NaN wins over sign, and signed zero is exact
  always_comb begin
    spec_res_s = PINF;
    spec_inv_s = 1'b0;
    if (cls_s.is_nan) begin
      spec_res_s = QNAN;
    end else if (cls_s.is_zero) begin
      spec_res_s = {cls_s.sign, 31'd0};
    end else if (cls_s.sign) begin
      spec_res_s = QNAN;
      spec_inv_s = 1'b1;
    end else begin
      spec_res_s = PINF;
    end
  end

  // Pulse special_valid for one cycle after a special accept
  always_comb begin
    if (accept_s && is_special_s) begin
      special_valid_d  = 1'b1;
      special_result_d = spec_res_s;
      invalid_d        = spec_inv_s;
    end else begin
      special_valid_d  = 1'b0;
      special_result_d = special_result_q;
      invalid_d        = 1'b0;
    end
  end

  // Special result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      special_valid_q  <= 1'b0;
      special_result_q <= 32'd0;
      invalid_q        <= 1'b0;
    end else begin
      special_valid_q  <= special_valid_d;
      special_result_q <= special_result_d;
      invalid_q        <= invalid_d;
    end
  end

  assign special_valid  = special_valid_q;
  assign special_result = special_result_q;
  assign invalid        = invalid_q;

endmodule

// File: tb/tb_sqrt_prenorm.sv
// Bench for sqrt_prenorm: table of operands with hand-derived results,
// a scoreboard queue filled at accept and drained by an output monitor,
// plus directed busy-core and reset-during-NORM sequences.
module tb_sqrt_prenorm;

  typedef struct {
    logic [31:0] op;
    logic        spec;
    logic [49:0] rad;
    logic [7:0]  expo;
    logic [31:0] res;
    logic        inv;
    int          lat;
  } vec_t;

  typedef struct {
    logic        spec;
    logic [49:0] rad;
    logic [7:0]  expo;
    logic [31:0] res;
    logic        inv;
    int          lat;
    int          acc_cyc;
  } exp_t;

  localparam int NVEC = 17;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] operand;
  logic        core_busy;
  logic        core_start;
  logic [49:0] radicand;
  logic [7:0]  exp_out;
  logic        special_valid;
  logic [31:0] special_result;
  logic        invalid;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  exp_t sb_q[$];
  exp_t got;
  logic prev_start = 1'b0;
  logic prev_spec  = 1'b0;
  vec_t vecs [NVEC];

  sqrt_prenorm dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .operand        (operand),
    .core_busy      (core_busy),
    .core_start     (core_start),
    .radicand       (radicand),
    .exp_out        (exp_out),
    .special_valid  (special_valid),
    .special_result (special_result),
    .invalid        (invalid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  // Output monitor: samples 2 time units after the falling edge
  always @(negedge clk) begin
    #2;
    if (!reset) begin
      if (core_start && special_valid) flag("start_and_special_same_cycle");
      if (core_start) begin
        check("start_not_back_to_back", 64'(prev_start), 64'd0);
        if (sb_q.size() == 0) begin
          flag("unexpected_core_start");
        end else begin
          got = sb_q.pop_front();
          check("start_for_normal_operand", 64'(got.spec), 64'd0);
          check("radicand", 64'(radicand), 64'(got.rad));
          check("exp_out", 64'(exp_out), 64'(got.expo));
          check("start_latency", 64'(cyc - got.acc_cyc), 64'(got.lat));
        end
      end
      if (special_valid) begin
        check("special_single_pulse", 64'(prev_spec), 64'd0);
        if (sb_q.size() == 0) begin
          flag("unexpected_special_valid");
        end else begin
          got = sb_q.pop_front();
          check("special_for_special_operand", 64'(got.spec), 64'd1);
          check("special_result", 64'(special_result), 64'(got.res));
          check("invalid", 64'(invalid), 64'(got.inv));
          check("special_latency", 64'(cyc - got.acc_cyc), 64'(got.lat));
        end
      end
    end
    prev_start = core_start;
    prev_spec  = special_valid;
  end

  task automatic send(input logic [31:0] op, input exp_t ex, input logic track);
    int t = 0;
    @(negedge clk); #1;
    while (!in_ready && t < 200) begin
      @(negedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      flag("in_ready_timeout");
    end else begin
      operand  = op;
      in_valid = 1'b1;
      ex.acc_cyc = cyc;
      if (track) sb_q.push_back(ex);
      @(negedge clk); #1;
      in_valid = 1'b0;
      operand  = 32'h0;
    end
  endtask

  task automatic drain();
    int t = 0;
    while (sb_q.size() != 0 && t < 200) begin
      @(negedge clk); #3;
      t++;
    end
    if (sb_q.size() != 0) begin
      flag("output_timeout");
      sb_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t ex;

    //          operand       spec  radicand              exp     result        inv  lat
    vecs[0]  = '{32'h40800000, 1'b0, 50'h1000000000000, 8'd128, 32'h00000000, 1'b0, 1};
    vecs[1]  = '{32'h40000000, 1'b0, 50'h2000000000000, 8'd127, 32'h00000000, 1'b0, 1};
    vecs[2]  = '{32'h3F800000, 1'b0, 50'h1000000000000, 8'd127, 32'h00000000, 1'b0, 1};
    vecs[3]  = '{32'h3FC00000, 1'b0, 50'h1800000000000, 8'd127, 32'h00000000, 1'b0, 1};
    vecs[4]  = '{32'h7F7FFFFF, 1'b0, 50'h3FFFFFC000000, 8'd190, 32'h00000000, 1'b0, 1};
    vecs[5]  = '{32'h00800000, 1'b0, 50'h1000000000000, 8'd64,  32'h00000000, 1'b0, 1};
    vecs[6]  = '{32'h00000001, 1'b0, 50'h2000000000000, 8'd52,  32'h00000000, 1'b0, 24};
    vecs[7]  = '{32'h00400000, 1'b0, 50'h2000000000000, 8'd63,  32'h00000000, 1'b0, 2};
    vecs[8]  = '{32'h00000003, 1'b0, 50'h1800000000000, 8'd53,  32'h00000000, 1'b0, 23};
    vecs[9]  = '{32'hBF800000, 1'b1, 50'h0,             8'd0,   32'h7FC00000, 1'b1, 1};
    vecs[10] = '{32'h80000000, 1'b1, 50'h0,             8'd0,   32'h80000000, 1'b0, 1};
    vecs[11] = '{32'h00000000, 1'b1, 50'h0,             8'd0,   32'h00000000, 1'b0, 1};
    vecs[12] = '{32'h7F800000, 1'b1, 50'h0,             8'd0,   32'h7F800000, 1'b0, 1};
    vecs[13] = '{32'hFF800000, 1'b1, 50'h0,             8'd0,   32'h7FC00000, 1'b1, 1};
    vecs[14] = '{32'h7FC00001, 1'b1, 50'h0,             8'd0,   32'h7FC00000, 1'b0, 1};
    vecs[15] = '{32'hFFC00000, 1'b1, 50'h0,             8'd0,   32'h7FC00000, 1'b0, 1};
    vecs[16] = '{32'h80000001, 1'b1, 50'h0,             8'd0,   32'h7FC00000, 1'b1, 1};

    reset     = 1'b1;
    in_valid  = 1'b0;
    operand   = 32'h0;
    core_busy = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_core_start", 64'(core_start), 64'd0);
    check("reset_special_valid", 64'(special_valid), 64'd0);
    check("reset_invalid", 64'(invalid), 64'd0);
    check("reset_radicand", 64'(radicand), 64'd0);
    check("reset_exp_out", 64'(exp_out), 64'd0);
    check("reset_special_result", 64'(special_result), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    reset = 1'b0;

    // Table-driven operands, core always idle
    for (int i = 0; i < NVEC; i++) begin
      ex.spec = vecs[i].spec;
      ex.rad  = vecs[i].rad;
      ex.expo = vecs[i].expo;
      ex.res  = vecs[i].res;
      ex.inv  = vecs[i].inv;
      ex.lat  = vecs[i].lat;
      ex.acc_cyc = 0;
      send(vecs[i].op, ex, 1'b1);
      drain();
      if (!vecs[i].spec) begin
        repeat (3) begin
          @(negedge clk); #1;
        end
        check("radicand_held", 64'(radicand), 64'(vecs[i].rad));
        check("exp_out_held", 64'(exp_out), 64'(vecs[i].expo));
        check("idle_after_start", 64'(in_ready), 64'd1);
      end
    end

    // Busy core: 4.0 waits in ISSUE for 10 cycles, then starts once
    core_busy = 1'b1;
    ex = '{1'b0, 50'h1000000000000, 8'd128, 32'h0, 1'b0, 11, 0};
    send(32'h40800000, ex, 1'b1);
    for (int k = 0; k < 10; k++) begin
      check("busy_no_start", 64'(core_start), 64'd0);
      check("busy_not_ready", 64'(in_ready), 64'd0);
      @(negedge clk); #1;
    end
    core_busy = 1'b0;
    drain();
    @(negedge clk); #1;
    check("ready_after_busy_start", 64'(in_ready), 64'd1);

    // Reset while normalising a subnormal: nothing is issued
    ex = '{1'b0, 50'h2000000000000, 8'd52, 32'h0, 1'b0, 24, 0};
    send(32'h00000001, ex, 1'b0);
    repeat (4) begin
      @(negedge clk); #1;
    end
    check("mid_norm_not_ready", 64'(in_ready), 64'd0);
    reset = 1'b1;
    @(negedge clk); #1;
    check("reset_mid_norm_radicand", 64'(radicand), 64'd0);
    check("reset_mid_norm_exp_out", 64'(exp_out), 64'd0);
    reset = 1'b0;
    @(negedge clk); #1;
    check("ready_after_reset_release", 64'(in_ready), 64'd1);
    repeat (30) begin
      @(negedge clk); #1;
    end
    ex = '{1'b0, 50'h1000000000000, 8'd128, 32'h0, 1'b0, 1, 0};
    send(32'h40800000, ex, 1'b1);
    drain();

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
